alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the 16-bit ALU.
- Takes a fetched 16-bit instruction plus register-file read data and produces the 8-bit ALU opcode, both ALU operands and the writeback target.
- Holds them in a registered ID/EX slot with valid/ready handshake, flush and single-source forwarding.
- Sits between the fetch stage and the ALU/EX stage.

Parameters:
T_REG_IDX, 4'd8, destination index used for the T flag register (CMP, SLT)
CNT_W, 16, width of the issued-instruction and illegal-instruction counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
if_valid  input  1  fetch offers an instruction
if_instr  input  16  instruction word
if_ready  output  1  stage can accept this cycle
rf_rx_addr  output  3  register-file read address A = if_instr[10:8], combinational
rf_ry_addr  output  3  register-file read address B = if_instr[7:5], combinational
rf_rx_data  input  16  read data for rf_rx_addr, same cycle
rf_ry_data  input  16  read data for rf_ry_addr, same cycle
fwd_en  input  1  EX/MEM result is being written this cycle
fwd_addr  input  4  destination index of that result
fwd_data  input  16  value of that result
flush  input  1  kill the held and offered instruction
out_ready  input  1  EX stage accepts issued slot
out_valid  output  1  issued slot valid
alu_opcode  output  8  ALU opcode
alu_in1  output  16  ALU operand 1
alu_in2  output  16  ALU operand 2
wb_en  output  1  result is written back
wb_addr  output  4  writeback index (0-7 GPR, T_REG_IDX = T)
illegal  output  1  registered, one-cycle pulse: illegal encoding accepted
issue_cnt  output  CNT_W  count of accepted instructions, wraps
illegal_cnt  output  CNT_W  count of accepted illegal encodings, wraps, saturates never

Behaviour:
- Reset (rst low, async) clears all outputs to 0: out_valid, alu_opcode, alu_in1, alu_in2, wb_en, wb_addr, illegal, issue_cnt, illegal_cnt.
- ALU opcode codes:
  - ADD 0x19, SUB 0x1A, AND 0x1B, OR 0x1C, XOR 0x1D, NOT 0x1E
  - SLL 0x1F, SRL 0x20, SRA 0x21
  - EQUAL 0x23, LESSTHEN 0x25, EMPTY 0x0B
- Handshake:
  - if_ready = !out_valid | out_ready (combinational).
  - accept = if_valid & if_ready & !flush.
  - Latency 1 cycle: on an accept edge the slot loads the decode and out_valid is 1 next cycle.
  - Held slot outputs stay stable while out_valid & !out_ready.
  - out_valid falls after out_ready with no new accept.
- Flush: out_valid goes 0 at the next edge and the offered instruction is dropped. Flush has priority over accept. Counters do not increment for a dropped instruction.
- Forwarding: an operand taken from register r uses fwd_data when fwd_en & fwd_addr=={1'b0,r}, otherwise the rf data. Forwarding is applied at accept time only.
- Decode, by bits [15:11] and function field; rx = [10:8], ry = [7:5], rz = [4:2]:
  - 11100, [1:0]=01, ADDU: ADD, in1=rx, in2=ry, wb rz.
  - 11100, [1:0]=11, SUBU: SUB, in1=rx, in2=ry, wb rz.
  - 11101, [4:0]=01100 AND / 01101 OR / 01110 XOR: in1=rx, in2=ry, wb rx.
  - 11101, 01111, NOT: in1=0, in2=ry, wb rx.
  - 11101, 01010, CMP: EQUAL, in1=rx, in2=ry, wb T_REG_IDX.
  - 11101, 00010, SLT: LESSTHEN, in1=rx, in2=ry, wb T_REG_IDX.
  - 00110 shifts, [1:0]=00 SLL / 10 SRL / 11 SRA: in1 = zero-extended imm3 [4:2], in2=ry, wb rx. An imm3 of 0 passes as 0; the ALU interprets it as shift by 8.
  - 01001, ADDIU: ADD, in1=rx, in2 = sign-extended [7:0], wb rx.
  - 01101, LI: ADD, in1=0, in2 = zero-extended [7:0], wb rx.
  - 0x0800, NOP: EMPTY, in1=in2=0, wb_en=0.
  - Anything else: EMPTY, operands 0, wb_en=0, illegal=1 for the cycle the slot is loaded, illegal_cnt+1.
  - Every legal non-NOP instruction sets wb_en=1.
- Counters: issue_cnt increments on every accept, including NOP and illegal. Both counters wrap from all-ones to 0.
- Reset mid-stall drops the held slot immediately; out_valid=0 asynchronously.

Test Plan:
- Reset with rst=0 while out_valid=1 -> all outputs 0 immediately; after release, if_ready=1.
- ADDU 0xE16D (rx=1, ry=3, rz=3), rf data 0x0005/0x0007 -> next cycle out_valid=1, opcode 0x19, in1=0x0005, in2=0x0007, wb_en=1, wb_addr=3.
- ADDIU r2,#0xFF (0x4AFF), rf_rx_data=0x0010 -> opcode 0x19, in1=0x0010, in2=0xFFFF, wb_addr=2. With fwd_en=1, fwd_addr=2, fwd_data=0x1234 -> in1=0x1234.
- SLL r1,r2,#0 (0x3140) -> opcode 0x1F, in1=0x0000, in2=r2 data, wb_addr=1. CMP 0xE94A -> opcode 0x23, wb_addr=8.
- Hold out_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, outputs unchanged, issue_cnt unchanged. Raise out_ready -> next instruction loads one edge later.
- Illegal 0xFFFF accepted -> illegal pulses 1 cycle, illegal_cnt=1, opcode 0x0B, wb_en=0. flush=1 with if_valid=1 -> out_valid=0 next cycle, issue_cnt unchanged.

Source files
------------

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Decode/issue stage for the 16-bit ALU. Decodes a fetched
//               instruction into ALU opcode, operands and writeback target,
//               applies single-source forwarding, and holds the result in a
//               registered ID/EX slot with valid/ready handshake and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter logic [3:0]  T_REG_IDX = 4'd8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [15:0]      if_instr,
  output logic             if_ready,
  output logic [2:0]       rf_rx_addr,
  output logic [2:0]       rf_ry_addr,
  input  logic [15:0]      rf_rx_data,
  input  logic [15:0]      rf_ry_data,
  input  logic             fwd_en,
  input  logic [3:0]       fwd_addr,
  input  logic [15:0]      fwd_data,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       alu_opcode,
  output logic [15:0]      alu_in1,
  output logic [15:0]      alu_in2,
  output logic             wb_en,
  output logic [3:0]       wb_addr,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  // ALU opcode codes
  localparam logic [7:0] OP_ADD   = 8'h19;
  localparam logic [7:0] OP_SUB   = 8'h1A;
  localparam logic [7:0] OP_AND   = 8'h1B;
  localparam logic [7:0] OP_OR    = 8'h1C;
  localparam logic [7:0] OP_XOR   = 8'h1D;
  localparam logic [7:0] OP_NOT   = 8'h1E;
  localparam logic [7:0] OP_SLL   = 8'h1F;
  localparam logic [7:0] OP_SRL   = 8'h20;
  localparam logic [7:0] OP_SRA   = 8'h21;
  localparam logic [7:0] OP_EQUAL = 8'h23;
  localparam logic [7:0] OP_LT    = 8'h25;
  localparam logic [7:0] OP_EMPTY = 8'h0B;

  // Major opcode field values
  localparam logic [4:0] MAJ_RRR   = 5'b11100;
  localparam logic [4:0] MAJ_RR    = 5'b11101;
  localparam logic [4:0] MAJ_SHIFT = 5'b00110;
  localparam logic [4:0] MAJ_ADDIU = 5'b01001;
  localparam logic [4:0] MAJ_LI    = 5'b01101;
  localparam logic [15:0] NOP_WORD = 16'h0800;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]  major;
  logic [2:0]  rx;
  logic [2:0]  ry;
  logic [2:0]  rz;
  logic [15:0] rx_val;
  logic [15:0] ry_val;
  logic        accept;

  logic [7:0]  d_opcode;
  logic [15:0] d_in1;
  logic [15:0] d_in2;
  logic        d_wb_en;
  logic [3:0]  d_wb_addr;
  logic        d_illegal;

  assign major = if_instr[15:11];
  assign rx    = if_instr[10:8];
  assign ry    = if_instr[7:5];
  assign rz    = if_instr[4:2];

  assign rf_rx_addr = rx;
  assign rf_ry_addr = ry;

  // The slot can take a new instruction when empty or being drained this cycle
  assign if_ready = !out_valid | out_ready;
  assign accept   = if_valid & if_ready & ~flush;

  // Operand values with the in-flight EX/MEM result bypassed over the RF read
  assign rx_val = (fwd_en && (fwd_addr == {1'b0, rx})) ? fwd_data : rf_rx_data;
  assign ry_val = (fwd_en && (fwd_addr == {1'b0, ry})) ? fwd_data : rf_ry_data;

  // Instruction decode; anything not matched falls through as illegal
  always_comb begin
    d_opcode  = OP_EMPTY;
    d_in1     = 16'h0000;
    d_in2     = 16'h0000;
    d_wb_en   = 1'b0;
    d_wb_addr = 4'h0;
    d_illegal = 1'b1;
    case (major)
      MAJ_RRR: begin
        if (if_instr[1:0] == 2'b01 || if_instr[1:0] == 2'b11) begin
          d_opcode  = (if_instr[1]) ? OP_SUB : OP_ADD;
          d_in1     = rx_val;
          d_in2     = ry_val;
          d_wb_en   = 1'b1;
          d_wb_addr = {1'b0, rz};
          d_illegal = 1'b0;
        end
      end
      MAJ_RR: begin
        d_in1     = rx_val;
        d_in2     = ry_val;
        d_wb_en   = 1'b1;
        d_wb_addr = {1'b0, rx};
        d_illegal = 1'b0;
        case (if_instr[4:0])
          5'b01100: d_opcode = OP_AND;
          5'b01101: d_opcode = OP_OR;
          5'b01110: d_opcode = OP_XOR;
          5'b01111: begin
            d_opcode = OP_NOT;
            d_in1    = 16'h0000;
          end
          5'b01010: begin
            d_opcode  = OP_EQUAL;
            d_wb_addr = T_REG_IDX;
          end
          5'b00010: begin
            d_opcode  = OP_LT;
            d_wb_addr = T_REG_IDX;
          end
          default: begin
            d_in1     = 16'h0000;
            d_in2     = 16'h0000;
            d_wb_en   = 1'b0;
            d_wb_addr = 4'h0;
            d_illegal = 1'b1;
          end
        endcase
      end
      MAJ_SHIFT: begin
        if (if_instr[1:0] != 2'b01) begin
          // imm3 of 0 is passed through; the ALU treats it as a shift by 8
          case (if_instr[1:0])
            2'b00:   d_opcode = OP_SLL;
            2'b10:   d_opcode = OP_SRL;
            default: d_opcode = OP_SRA;
          endcase
          d_in1     = {13'h0000, if_instr[4:2]};
          d_in2     = ry_val;
          d_wb_en   = 1'b1;
          d_wb_addr = {1'b0, rx};
          d_illegal = 1'b0;
        end
      end
      MAJ_ADDIU: begin
        d_opcode  = OP_ADD;
        d_in1     = rx_val;
        d_in2     = {{8{if_instr[7]}}, if_instr[7:0]};
        d_wb_en   = 1'b1;
        d_wb_addr = {1'b0, rx};
        d_illegal = 1'b0;
      end
      MAJ_LI: begin
        d_opcode  = OP_ADD;
        d_in2     = {8'h00, if_instr[7:0]};
        d_wb_en   = 1'b1;
        d_wb_addr = {1'b0, rx};
        d_illegal = 1'b0;
      end
      default: begin
        if (if_instr == NOP_WORD) begin
          d_illegal = 1'b0;
        end
      end
    endcase
  end

  // ID/EX slot, illegal pulse and counters; flush beats accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      alu_opcode  <= 8'h00;
      alu_in1     <= 16'h0000;
      alu_in2     <= 16'h0000;
      wb_en       <= 1'b0;
      wb_addr     <= 4'h0;
      illegal     <= 1'b0;
      issue_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      illegal <= accept & d_illegal;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        alu_opcode <= d_opcode;
        alu_in1    <= d_in1;
        alu_in2    <= d_in2;
        wb_en      <= d_wb_en;
        wb_addr    <= d_wb_addr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        issue_cnt <= issue_cnt + CNT_ONE;
        if (d_illegal) begin
          illegal_cnt <= illegal_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Scoreboard bench for alu_issue_stage. A driver issues directed
//               and random instructions, predicts each accepted slot from an
//               instruction-level reference decode and queues it; a monitor
//               pops and compares when the slot is handed to EX.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  typedef struct packed {
    logic [7:0]  opc;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        wben;
    logic [3:0]  wba;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [15:0] if_instr = 16'h0;
  logic        if_ready;
  logic [2:0]  rf_rx_addr;
  logic [2:0]  rf_ry_addr;
  logic [15:0] rf_rx_data = 16'h0;
  logic [15:0] rf_ry_data = 16'h0;
  logic        fwd_en = 1'b0;
  logic [3:0]  fwd_addr = 4'h0;
  logic [15:0] fwd_data = 16'h0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic        illegal;
  logic [15:0] issue_cnt;
  logic [15:0] illegal_cnt;

  alu_issue_stage #(.T_REG_IDX(4'd8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .rf_rx_addr(rf_rx_addr), .rf_ry_addr(rf_ry_addr),
    .rf_rx_data(rf_rx_data), .rf_ry_data(rf_ry_data),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .wb_en(wb_en), .wb_addr(wb_addr), .illegal(illegal),
    .issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic mon_en = 1'b0;

  // Model state seen this cycle (m_*) and predicted after the next edge (n_*)
  logic        m_valid = 1'b0, n_valid = 1'b0;
  logic        m_ill = 1'b0, n_ill = 1'b0;
  logic [15:0] m_icnt = 16'h0, n_icnt = 16'h0;
  logic [15:0] m_lcnt = 16'h0, n_lcnt = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: what the ALU should be asked to do
  function automatic exp_t ref_decode(input logic [15:0] ins, input logic [15:0] a,
                                      input logic [15:0] b, input logic fe,
                                      input logic [3:0] fa, input logic [15:0] fd);
    exp_t e;
    logic [15:0] va, vb;
    int rx, ry, rz;
    rx = int'(ins[10:8]);
    ry = int'(ins[7:5]);
    rz = int'(ins[4:2]);
    va = (fe && int'(fa) == rx) ? fd : a;
    vb = (fe && int'(fa) == ry) ? fd : b;
    e = '{opc: 8'h0B, in1: 16'h0, in2: 16'h0, wben: 1'b0, wba: 4'h0, ill: 1'b0};
    casez (ins)
      16'b11100_???????_??_01: e = '{8'h19, va, vb, 1'b1, 4'(rz), 1'b0};
      16'b11100_???????_??_11: e = '{8'h1A, va, vb, 1'b1, 4'(rz), 1'b0};
      16'b11101_??????_01100:  e = '{8'h1B, va, vb, 1'b1, 4'(rx), 1'b0};
      16'b11101_??????_01101:  e = '{8'h1C, va, vb, 1'b1, 4'(rx), 1'b0};
      16'b11101_??????_01110:  e = '{8'h1D, va, vb, 1'b1, 4'(rx), 1'b0};
      16'b11101_??????_01111:  e = '{8'h1E, 16'h0, vb, 1'b1, 4'(rx), 1'b0};
      16'b11101_??????_01010:  e = '{8'h23, va, vb, 1'b1, 4'd8, 1'b0};
      16'b11101_??????_00010:  e = '{8'h25, va, vb, 1'b1, 4'd8, 1'b0};
      16'b00110_?????????_00:  e = '{8'h1F, 16'(rz), vb, 1'b1, 4'(rx), 1'b0};
      16'b00110_?????????_10:  e = '{8'h20, 16'(rz), vb, 1'b1, 4'(rx), 1'b0};
      16'b00110_?????????_11:  e = '{8'h21, 16'(rz), vb, 1'b1, 4'(rx), 1'b0};
      16'b01001_???????????:   e = '{8'h19, va, 16'($signed(ins[7:0])), 1'b1, 4'(rx), 1'b0};
      16'b01101_???????????:   e = '{8'h19, 16'h0, 16'(ins[7:0]), 1'b1, 4'(rx), 1'b0};
      16'h0800:                e.ill = 1'b0;
      default:                 e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One cycle of stimulus, applied 2 time units after the rising edge
  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] b, input logic fe, input logic [3:0] fa,
                       input logic [15:0] fd, input logic fl, input logic rdy);
    logic acc;
    exp_t e;
    @(posedge clk);
    m_valid = n_valid; m_ill = n_ill; m_icnt = n_icnt; m_lcnt = n_lcnt;
    #2;
    if_valid = v; if_instr = ins; rf_rx_data = a; rf_ry_data = b;
    fwd_en = fe; fwd_addr = fa; fwd_data = fd; flush = fl; out_ready = rdy;
    #1;
    chk("rf_rx_addr", 32'(rf_rx_addr), 32'(ins[10:8]));
    chk("rf_ry_addr", 32'(rf_ry_addr), 32'(ins[7:5]));
    acc = v && (!m_valid || rdy) && !fl;
    e = ref_decode(ins, a, b, fe, fa, fd);
    n_valid = fl ? 1'b0 : (acc ? 1'b1 : (rdy ? 1'b0 : m_valid));
    n_ill = acc && e.ill;
    if (acc) begin
      sb.push_back(e);
      n_icnt = m_icnt + 16'd1;
      if (e.ill) n_lcnt = m_lcnt + 16'd1;
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 16'h0000, 16'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, rdy);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r;
    logic [4:0] fns[6];
    logic [1:0] sh[3];
    fns = '{5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b01010, 5'b00010};
    sh  = '{2'b00, 2'b10, 2'b11};
    r = 16'($urandom());
    case ($urandom_range(0, 7))
      0: return {5'b11100, r[10:2], ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11};
      1: return {5'b11101, r[10:5], fns[$urandom_range(0, 5)]};
      2: return {5'b00110, r[10:2], sh[$urandom_range(0, 2)]};
      3: return {5'b01001, r[10:0]};
      4: return {5'b01101, r[10:0]};
      5: return 16'h0800;
      default: return r;
    endcase
  endfunction

  // Monitor: checks per-cycle state and pops the scoreboard on each handoff
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      chk("if_ready", 32'(if_ready), 32'(!m_valid || out_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("illegal", 32'(illegal), 32'(m_ill));
      chk("issue_cnt", 32'(issue_cnt), 32'(m_icnt));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_lcnt));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("alu_opcode", 32'(alu_opcode), 32'(e.opc));
          chk("alu_in1", 32'(alu_in1), 32'(e.in1));
          chk("alu_in2", 32'(alu_in2), 32'(e.in2));
          chk("wb_en", 32'(wb_en), 32'(e.wben));
          chk("wb_addr", 32'(wb_addr), 32'(e.wba));
        end
      end else if (out_valid && flush && sb.size() != 0) begin
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    // Power-on reset
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    mon_en = 1'b1;

    // Directed sequence
    drive(1'b1, 16'hE16D, 16'h0005, 16'h0007, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 16'h4AFF, 16'h0010, 16'h3333, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("addu_opcode", 32'(alu_opcode), 32'h19);
    chk("addu_in1", 32'(alu_in1), 32'h0005);
    chk("addu_in2", 32'(alu_in2), 32'h0007);
    chk("addu_wb_addr", 32'(wb_addr), 32'd3);
    drive(1'b1, 16'h4AFF, 16'h0010, 16'h0000, 1'b1, 4'd2, 16'h1234, 1'b0, 1'b1);
    drive(1'b1, 16'h3140, 16'h9999, 16'h00AB, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("fwd_in1", 32'(alu_in1), 32'h1234);
    chk("fwd_in2", 32'(alu_in2), 32'hFFFF);
    drive(1'b1, 16'hE94A, 16'h0001, 16'h0001, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hE16D, 16'h0AAA, 16'h0BBB, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0);
      chk("stall_if_ready", 32'(if_ready), 32'd0);
    end
    drive(1'b1, 16'hE16D, 16'h0AAA, 16'h0BBB, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 16'h0800, 16'h0000, 16'h0000, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    chk("ill_pulse", 32'(illegal), 32'd1);
    chk("ill_opcode", 32'(alu_opcode), 32'h0B);
    chk("ill_wb_en", 32'(wb_en), 32'd0);
    chk("ill_cnt", 32'(illegal_cnt), 32'd1);
    idle(1'b0);
    drive(1'b1, 16'hE16D, 16'h1111, 16'h2222, 1'b0, 4'h0, 16'h0, 1'b1, 1'b0);
    idle(1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_issue_cnt", 32'(issue_cnt), 32'd8);

    // Asynchronous reset while a slot is stalled
    drive(1'b1, 16'hE16D, 16'h0005, 16'h0007, 1'b0, 4'h0, 16'h0, 1'b0, 1'b1);
    idle(1'b0);
    mon_en = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in1", 32'(alu_in1), 32'd0);
    chk("arst_wb_en", 32'(wb_en), 32'd0);
    chk("arst_issue_cnt", 32'(issue_cnt), 32'd0);
    sb.delete();
    m_valid = 1'b0; n_valid = 1'b0; m_ill = 1'b0; n_ill = 1'b0;
    m_icnt = 16'h0; n_icnt = 16'h0; m_lcnt = 16'h0; n_lcnt = 16'h0;
    rst = 1'b1;
    #1;
    chk("arst_if_ready", 32'(if_ready), 32'd1);
    mon_en = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      logic [3:0] fa;
      ins = rand_instr();
      case ($urandom_range(0, 3))
        0: fa = {1'b0, ins[10:8]};
        1: fa = {1'b0, ins[7:5]};
        default: fa = 4'($urandom_range(0, 15));
      endcase
      drive($urandom_range(0, 9) < 8, ins, 16'($urandom()), 16'($urandom()),
            $urandom_range(0, 1) != 0, fa, 16'($urandom()),
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    // Drain
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
